// File: rtl/spi_capture_pkg.sv
// Shared definitions for the SPI capture trigger controller.
// Holds the capture state encoding, the Avalon-MM register map, the CTRL
// register bit positions and the masked byte-match helper.
package spi_capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3
    } capture_state_t;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_MATCH   = 3'd1;
    localparam logic [2:0] ADDR_POSTCNT = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_TRIGPOS = 3'd4;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_SRC   = 2;

    // Only bits set in the mask take part in the compare, so a zero mask
    // makes every byte a match.
    function automatic logic byte_match(input logic [7:0] sel_byte,
                                        input logic [7:0] value,
                                        input logic [7:0] mask);
        return ((sel_byte ^ value) & mask) == 8'h00;
    endfunction

endpackage

// File: rtl/spi_capture_trigger_controller_gate.sv
// spi_byte_event_gate
// Turns the sniffer's level-pulse byte strobe into a one-cycle byte event and
// gates the strobe towards the debugger without ever cutting a pulse short.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   buffer_changed      raw byte-complete strobe from the sniffer
//   gate_req            capture FSM wants strobes forwarded
//   byte_event          one-cycle pulse on the rising edge of buffer_changed
//   buffer_changed_out  buffer_changed passed through the gate
module spi_byte_event_gate (
    input  logic clock,
    input  logic reset,
    input  logic buffer_changed,
    input  logic gate_req,
    output logic byte_event,
    output logic buffer_changed_out
);

    logic bc_q;
    logic gate;

    // bc_q resets high so a strobe already asserted out of reset is not seen
    // as a new byte. The gate only follows gate_req while the strobe is low,
    // which keeps every forwarded pulse whole.
    always_ff @(posedge clock) begin
        if (reset) begin
            bc_q <= 1'b1;
            gate <= 1'b0;
        end else begin
            bc_q <= buffer_changed;
            if (!buffer_changed) begin
                gate <= gate_req;
            end
        end
    end

    assign byte_event         = !bc_q && buffer_changed;
    assign buffer_changed_out = buffer_changed && gate;

endmodule

// File: rtl/spi_capture_trigger_controller.sv
// spi_capture_trigger_controller
// Sequences an SPI buffer debugger capture: arm, trigger on a masked byte
// match, count post-trigger bytes, then freeze by closing the strobe gate so
// the debugger ring keeps pre-trigger history plus N post-trigger bytes.
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   io_Avalon_*              register interface (readdata combinational,
//                            waitrequest tied 0)
//   io_MISO_Buffer           current MISO byte
//   io_MOSI_Buffer           current MOSI byte
//   io_BufferChanged         byte-complete strobe from the sniffer
//   io_BufferChangedOut      gated strobe to the debugger
//   io_Triggered             high in POST and DONE
//   io_Done                  high in DONE
// Registers: 0 CTRL (arm, abort, src), 1 MATCH {mask,value}, 2 POSTCNT,
//   3 STATUS {byte_count,state} read-only, 4 TRIGPOS read-only.
module spi_capture_trigger_controller
    import spi_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  io_Avalon_address,
    input  logic        io_Avalon_read,
    output logic [31:0] io_Avalon_readdata,
    input  logic        io_Avalon_write,
    input  logic [31:0] io_Avalon_writedata,
    output logic        io_Avalon_waitrequest,
    input  logic [7:0]  io_MISO_Buffer,
    input  logic [7:0]  io_MOSI_Buffer,
    input  logic        io_BufferChanged,
    output logic        io_BufferChangedOut,
    output logic        io_Triggered,
    output logic        io_Done
);

    capture_state_t   state;
    capture_state_t   state_next;

    logic             src;
    logic [7:0]       match_value;
    logic [7:0]       match_mask;
    logic [CNT_W-1:0] postcnt;
    logic [CNT_W-1:0] byte_count;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] trigpos;

    logic             byte_event;
    logic             gate_req;
    logic             byte_hit;
    logic             cfg_open;
    logic             ctrl_write;
    logic             abort_req;
    logic             arm_req;

    logic             clear_count;
    logic             load_remain;
    logic             count_en;
    logic             remain_dec;
    logic             trig_capture;

    logic             unused_inputs;

    assign unused_inputs = ^{io_Avalon_read, io_Avalon_writedata[31:16]};

    spi_byte_event_gate u_gate (
        .clock              (clock),
        .reset              (reset),
        .buffer_changed     (io_BufferChanged),
        .gate_req           (gate_req),
        .byte_event         (byte_event),
        .buffer_changed_out (io_BufferChangedOut)
    );

    assign byte_hit   = byte_match(src ? io_MISO_Buffer : io_MOSI_Buffer,
                                   match_value, match_mask);
    assign cfg_open   = (state == IDLE) || (state == DONE);
    assign ctrl_write = io_Avalon_write && (io_Avalon_address == ADDR_CTRL);
    assign abort_req  = ctrl_write && io_Avalon_writedata[CTRL_ABORT];
    assign arm_req    = ctrl_write && io_Avalon_writedata[CTRL_ARM];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort is checked first so it wins over an arm in the same write and
    // over a byte event or match in the same cycle.
    always_comb begin
        state_next   = state;
        clear_count  = 1'b0;
        load_remain  = 1'b0;
        count_en     = 1'b0;
        remain_dec   = 1'b0;
        trig_capture = 1'b0;
        if (abort_req) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_req) begin
                        state_next  = ARMED;
                        clear_count = 1'b1;
                        load_remain = 1'b1;
                    end
                end
                ARMED: begin
                    if (byte_event) begin
                        count_en = 1'b1;
                        if (byte_hit) begin
                            trig_capture = 1'b1;
                            state_next   = (postcnt != '0) ? POST : DONE;
                        end
                    end
                end
                POST: begin
                    if (byte_event) begin
                        count_en   = 1'b1;
                        remain_dec = 1'b1;
                        if (remain == CNT_W'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign gate_req     = (state == ARMED) || (state == POST);
    assign io_Triggered = (state == POST) || (state == DONE);
    assign io_Done      = (state == DONE);

    // Configuration is frozen while a capture is running. TRIGPOS takes the
    // count before the trigger byte is added, i.e. its zero-based index.
    always_ff @(posedge clock) begin
        if (reset) begin
            src         <= 1'b0;
            match_value <= 8'h00;
            match_mask  <= 8'h00;
            postcnt     <= '0;
            byte_count  <= '0;
            remain      <= '0;
            trigpos     <= '0;
        end else begin
            if (io_Avalon_write && cfg_open) begin
                case (io_Avalon_address)
                    ADDR_CTRL:    src <= io_Avalon_writedata[CTRL_SRC];
                    ADDR_MATCH: begin
                        match_value <= io_Avalon_writedata[7:0];
                        match_mask  <= io_Avalon_writedata[15:8];
                    end
                    ADDR_POSTCNT: postcnt <= io_Avalon_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (clear_count) begin
                byte_count <= '0;
            end else if (count_en && (byte_count != {CNT_W{1'b1}})) begin
                byte_count <= byte_count + CNT_W'(1);
            end
            if (load_remain) begin
                remain <= postcnt;
            end else if (remain_dec) begin
                remain <= remain - CNT_W'(1);
            end
            if (trig_capture) begin
                trigpos <= byte_count;
            end
        end
    end

    always_comb begin
        io_Avalon_readdata = 32'h0;
        case (io_Avalon_address)
            ADDR_CTRL:    io_Avalon_readdata = {29'h0, src, 2'b00};
            ADDR_MATCH:   io_Avalon_readdata = {16'h0, match_mask, match_value};
            ADDR_POSTCNT: io_Avalon_readdata = 32'(postcnt);
            ADDR_STATUS:  io_Avalon_readdata = (32'(byte_count) << 16) | {29'h0, state};
            ADDR_TRIGPOS: io_Avalon_readdata = 32'(trigpos);
            default:      io_Avalon_readdata = 32'h0;
        endcase
    end

    assign io_Avalon_waitrequest = 1'b0;

endmodule
